// File: rtl/app_stream_arbiter.sv
// Round-robin merge of N_CH credit-based packet streams into one credit-based link.
// Arbitration happens at packet boundaries, with an optional channel-ID flit and an output FIFO.
module app_stream_arbiter #(
  parameter int FLIT_SIZE  = 32,
  parameter int N_CH       = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16,
  parameter int TAG_EN     = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_CH-1:0]           src_tx_i,
  output logic [N_CH-1:0]           src_credit_o,
  input  logic [N_CH*FLIT_SIZE-1:0] src_data_i,
  input  logic [N_CH-1:0]           src_eoa_i,
  output logic                      tx_o,
  input  logic                      credit_i,
  output logic [FLIT_SIZE-1:0]      data_o,
  output logic                      eoa_o
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, TAG, LEN, PAYLOAD} state_t;

  state_t              state, state_next;
  logic [CH_W-1:0]     grant, grant_next, rr_ptr, rr_next, idx;
  logic [LEN_W-1:0]    count, count_next;
  logic [FLIT_SIZE-1:0] src_flit, push_data;
  logic [N_CH-1:0]     grant_oh;
  logic                sel_tx, credit_ok, xfer, push, pop, full, empty, found;

  logic [FLIT_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       occ;

  always_comb begin
    src_flit = '0;
    grant_oh = '0;
    sel_tx   = 1'b0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (CH_W'(c) == grant) begin
        src_flit    = src_data_i[c*FLIT_SIZE +: FLIT_SIZE];
        grant_oh[c] = 1'b1;
        sel_tx      = src_tx_i[c];
      end
    end
  end

  // Credit depends only on the registered full flag, never on a same-cycle pop.
  assign credit_ok = ((state == LEN) || (state == PAYLOAD)) && !full;
  assign xfer      = credit_ok && sel_tx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_next;
      grant  <= grant_next;
      rr_ptr <= rr_next;
      count  <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    rr_next    = rr_ptr;
    count_next = count;
    found      = 1'b0;
    idx        = '0;
    case (state)
      IDLE: begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          idx = CH_W'((32'(rr_ptr) + i) % N_CH);
          if (!found && src_tx_i[idx]) begin
            found      = 1'b1;
            grant_next = idx;
            rr_next    = CH_W'((32'(idx) + 1) % N_CH);
            state_next = (TAG_EN != 0) ? TAG : LEN;
          end
        end
      end
      TAG: if (!full) state_next = LEN;
      LEN: begin
        if (xfer) begin
          count_next = src_flit[LEN_W-1:0];
          state_next = (src_flit[LEN_W-1:0] == '0) ? IDLE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          count_next = count - 1'b1;
          if (count == LEN_W'(1)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    src_credit_o = '0;
    push         = 1'b0;
    push_data    = '0;
    case (state)
      TAG: begin
        push      = !full;
        push_data = FLIT_SIZE'(grant);
      end
      LEN, PAYLOAD: begin
        src_credit_o = credit_ok ? grant_oh : '0;
        push         = xfer;
        push_data    = src_flit;
      end
      default: ;
    endcase
  end

  assign full   = (occ == (PTR_W+1)'(FIFO_DEPTH));
  assign empty  = (occ == '0);
  assign tx_o   = !empty;
  assign data_o = empty ? '0 : mem[rd_ptr];
  assign pop    = tx_o && credit_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      eoa_o <= 1'b0;
    end else if ((&src_eoa_i) && (state == IDLE) && empty && (src_tx_i == '0)) begin
      eoa_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_app_stream_arbiter.sv
// Bench for app_stream_arbiter: vector table for cycle-exact behaviour plus
// queue-driven sources for back-pressure, end-of-applications and reset sequences.
module tb_app_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  src_tx, src_credit, src_eoa;
  logic [63:0] src_data;
  logic        tx, credit, eoa;
  logic [31:0] data;

  logic [1:0]  n_src_tx, n_src_credit, n_src_eoa;
  logic [63:0] n_src_data;
  logic        n_tx, n_credit, n_eoa;
  logic [31:0] n_data;

  app_stream_arbiter #(.FLIT_SIZE(32), .N_CH(2), .FIFO_DEPTH(4), .LEN_W(16), .TAG_EN(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .src_tx_i(src_tx), .src_credit_o(src_credit),
    .src_data_i(src_data), .src_eoa_i(src_eoa), .tx_o(tx), .credit_i(credit),
    .data_o(data), .eoa_o(eoa));

  app_stream_arbiter #(.FLIT_SIZE(32), .N_CH(2), .FIFO_DEPTH(4), .LEN_W(16), .TAG_EN(0)) dut_nt (
    .clk_i(clk), .rst_ni(rst_n), .src_tx_i(n_src_tx), .src_credit_o(n_src_credit),
    .src_data_i(n_src_data), .src_eoa_i(n_src_eoa), .tx_o(n_tx), .credit_i(n_credit),
    .data_o(n_data), .eoa_o(n_eoa));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] q0[$], q1[$], obs[$];
  bit          pend0, pend1;
  logic        sink_rdy;
  logic [1:0]  eoa_req;

  // One clock of the source/sink models around the main DUT.
  task automatic step();
    @(negedge clk);
    if (pend0) void'(q0.pop_front());
    if (pend1) void'(q1.pop_front());
    src_tx[0]      = (q0.size() != 0);
    src_tx[1]      = (q1.size() != 0);
    src_data[31:0] = (q0.size() != 0) ? q0[0] : 32'h0;
    src_data[63:32]= (q1.size() != 0) ? q1[0] : 32'h0;
    credit         = sink_rdy;
    src_eoa        = eoa_req;
    #1;
    pend0 = src_tx[0] && src_credit[0];
    pend1 = src_tx[1] && src_credit[1];
    if (tx && credit) obs.push_back(data);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while ((q0.size() != 0 || q1.size() != 0 || tx) && n < budget);
    check({name, " drained"}, {31'b0, (q0.size() == 0 && q1.size() == 0 && !tx)}, 32'd1);
  endtask

  task automatic check_obs(input string name, input logic [31:0] exp[$]);
    check({name, " count"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s[%0d]", name, i), (i < obs.size()) ? obs[i] : 32'hDEAD_BEEF, exp[i]);
    obs.delete();
  endtask

  typedef struct {
    bit          which;   // 0: tagged DUT, 1: untagged DUT
    logic [1:0]  tx;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        cr;
    logic [1:0]  e_cr;
    logic        e_tx;
    logic [31:0] e_data;
  } vec_t;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[15];
    logic [31:0] exp[$];

    tbl[0]  = '{1'b0, 2'b01, 32'hFFFF_0003, 32'h0, 1'b1, 2'b00, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 2'b01, 32'hFFFF_0003, 32'h0, 1'b1, 2'b00, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 2'b01, 32'hFFFF_0003, 32'h0, 1'b1, 2'b01, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 2'b01, 32'hA000_000A, 32'h0, 1'b1, 2'b01, 1'b1, 32'hFFFF_0003};
    tbl[4]  = '{1'b0, 2'b01, 32'hB000_000B, 32'h0, 1'b1, 2'b01, 1'b1, 32'hA000_000A};
    tbl[5]  = '{1'b0, 2'b01, 32'hC000_000C, 32'h0, 1'b1, 2'b01, 1'b1, 32'hB000_000B};
    tbl[6]  = '{1'b0, 2'b00, 32'h0,         32'h0, 1'b1, 2'b00, 1'b1, 32'hC000_000C};
    tbl[7]  = '{1'b0, 2'b00, 32'h0,         32'h0, 1'b1, 2'b00, 1'b0, 32'h0};
    // L=0 on ch1 (upper bits set but ignored for counting), then ch0 with L=1.
    tbl[8]  = '{1'b1, 2'b10, 32'h0,  32'hABCD_0000, 1'b1, 2'b00, 1'b0, 32'h0};
    tbl[9]  = '{1'b1, 2'b10, 32'h0,  32'hABCD_0000, 1'b1, 2'b10, 1'b0, 32'h0};
    tbl[10] = '{1'b1, 2'b01, 32'h1,  32'h0, 1'b1, 2'b00, 1'b1, 32'hABCD_0000};
    tbl[11] = '{1'b1, 2'b01, 32'h1,  32'h0, 1'b1, 2'b01, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 2'b01, 32'h55, 32'h0, 1'b1, 2'b01, 1'b1, 32'h1};
    tbl[13] = '{1'b1, 2'b00, 32'h0,  32'h0, 1'b1, 2'b00, 1'b1, 32'h55};
    tbl[14] = '{1'b1, 2'b00, 32'h0,  32'h0, 1'b1, 2'b00, 1'b0, 32'h0};

    src_tx = '0; src_data = '0; src_eoa = '0; credit = 1'b0;
    n_src_tx = '0; n_src_data = '0; n_src_eoa = '0; n_credit = 1'b0;
    sink_rdy = 1'b1; eoa_req = '0; pend0 = 0; pend1 = 0;

    repeat (2) @(negedge clk);
    #1;
    check("reset tx", {31'b0, tx}, 32'd0);
    check("reset data", data, 32'd0);
    check("reset credit", {30'b0, src_credit}, 32'd0);
    check("reset eoa", {31'b0, eoa}, 32'd0);
    check("reset nt tx", {31'b0, n_tx}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (tbl[i].which == 1'b0) begin
        src_tx = tbl[i].tx; src_data = {tbl[i].d1, tbl[i].d0}; credit = tbl[i].cr;
        n_src_tx = '0; n_credit = 1'b1;
      end else begin
        n_src_tx = tbl[i].tx; n_src_data = {tbl[i].d1, tbl[i].d0}; n_credit = tbl[i].cr;
        src_tx = '0; credit = 1'b1;
      end
      #1;
      if (tbl[i].which == 1'b0) begin
        check($sformatf("vec%0d credit", i), {30'b0, src_credit}, {30'b0, tbl[i].e_cr});
        check($sformatf("vec%0d tx", i), {31'b0, tx}, {31'b0, tbl[i].e_tx});
        check($sformatf("vec%0d data", i), data, tbl[i].e_data);
      end else begin
        check($sformatf("vec%0d credit", i), {30'b0, n_src_credit}, {30'b0, tbl[i].e_cr});
        check($sformatf("vec%0d tx", i), {31'b0, n_tx}, {31'b0, tbl[i].e_tx});
        check($sformatf("vec%0d data", i), n_data, tbl[i].e_data);
      end
    end
    n_src_tx = '0;

    // Both channels requesting, L=1 each; rr_ptr is 1 after the first packet, so ch1 leads.
    for (int k = 0; k < 3; k++) begin
      q0.push_back(32'd1); q0.push_back(32'h11);
      q1.push_back(32'd1); q1.push_back(32'h22);
    end
    drain("alt", 200);
    exp = '{32'd1, 32'd1, 32'h22, 32'd0, 32'd1, 32'h11,
            32'd1, 32'd1, 32'h22, 32'd0, 32'd1, 32'h11,
            32'd1, 32'd1, 32'h22, 32'd0, 32'd1, 32'h11};
    check_obs("alt", exp);

    // Back-pressure: FIFO fills with ID, L, p0, p1 then the source is blocked.
    sink_rdy = 1'b0;
    q0 = '{32'd5, 32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004};
    repeat (12) step();
    check("bp remaining", q0.size(), 32'd3);
    check("bp credit", {30'b0, src_credit}, 32'd0);
    check("bp tx", {31'b0, tx}, 32'd1);
    check("bp head", data, 32'd0);
    sink_rdy = 1'b1;
    drain("bp", 200);
    exp = '{32'd0, 32'd5, 32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003, 32'hB000_0004};
    check_obs("bp", exp);

    // End of applications with one packet parked in the FIFO.
    sink_rdy = 1'b0;
    eoa_req = 2'b11;
    q1 = '{32'd1, 32'h77};
    repeat (8) step();
    check("eoa accepted", q1.size(), 32'd0);
    check("eoa held low", {31'b0, eoa}, 32'd0);
    sink_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("eoa step%0d eoa", i), {31'b0, eoa}, (i >= 4) ? 32'd1 : 32'd0);
      check($sformatf("eoa step%0d tx", i), {31'b0, tx}, (i < 3) ? 32'd1 : 32'd0);
    end
    eoa_req = 2'b00;
    step();
    check("eoa sticky", {31'b0, eoa}, 32'd1);
    exp = '{32'd1, 32'd1, 32'h77};
    check_obs("eoa", exp);

    // Reset mid-PAYLOAD: count=2, FIFO holds ID, L, p0.
    sink_rdy = 1'b0;
    q0 = '{32'd3, 32'hC000_0001};
    repeat (8) step();
    check("mid credit", {30'b0, src_credit}, 32'd1);
    check("mid tx", {31'b0, tx}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    src_tx = 2'b11; src_data = {32'hEEEE_EEEE, 32'hDDDD_DDDD}; credit = 1'b1;
    #1;
    check("rst tx", {31'b0, tx}, 32'd0);
    check("rst credit", {30'b0, src_credit}, 32'd0);
    check("rst data", data, 32'd0);
    check("rst eoa", {31'b0, eoa}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("rst hold tx", {31'b0, tx}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    src_tx = '0;
    q0.delete(); q1.delete(); obs.delete(); pend0 = 0; pend1 = 0;
    sink_rdy = 1'b1;
    q0 = '{32'd1, 32'h88};
    q1 = '{32'd1, 32'h99};
    drain("post rst", 200);
    exp = '{32'd0, 32'd1, 32'h88, 32'd1, 32'd1, 32'h99};
    check_obs("post rst", exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
